// File: rtl/alu_issue_queue.sv
// alu_issue_queue
//   Command FIFO and issue sequencer in front of the FP ALU. Tagged commands
//   are buffered, then issued one at a time over the ALU's level-sensitive
//   start/valid_out handshake. Each result lands in a response register with
//   a valid/ready handshake. Exception flags accumulate in a sticky register,
//   and a timeout aborts an ALU that never reports done.
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_*                    command input, valid/ready (cmd_ready registered)
//   alu_op_a/op_b/op_code/
//   alu_mode_fp/round_mode   operands and control to the ALU, from issue register
//   alu_start                ALU start level (high only in ISSUE)
//   alu_result/flags/
//   alu_valid_out            ALU result, exception flags and done level
//   rsp_*                    response output, valid/ready
//   sticky_flags, sticky_clr accumulated flags and their clear
//   timeout_err              sticky ALU-timeout indication
//   busy                     work pending anywhere in the block
module alu_issue_queue #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_op_a,
    input  logic [31:0]      cmd_op_b,
    input  logic [2:0]       cmd_op_code,
    input  logic             cmd_mode_fp,
    input  logic [1:0]       cmd_round_mode,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      alu_op_a,
    output logic [31:0]      alu_op_b,
    output logic [2:0]       alu_op_code,
    output logic             alu_mode_fp,
    output logic [1:0]       alu_round_mode,
    output logic             alu_start,
    input  logic [31:0]      alu_result,
    input  logic             alu_valid_out,
    input  logic [4:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [4:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [4:0]       sticky_flags,
    input  logic             sticky_clr,
    output logic             timeout_err,
    output logic             busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [31:0] QNAN      = 32'h7FC0_0000;
    localparam logic [4:0]  FLG_INVAL = 5'b10000;

    typedef struct packed {
        logic [31:0]      op_a;
        logic [31:0]      op_b;
        logic [2:0]       op_code;
        logic             mode_fp;
        logic [1:0]       round_mode;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

    cmd_t             mem [DEPTH];
    cmd_t             head, iss;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    state_t           state, state_nxt;
    logic             push, pop, tmo_hit, rsp_load;
    logic [31:0]      ld_result;
    logic [4:0]       ld_flags;
    logic [TAG_W-1:0] ld_tag;

    assign head    = mem[rd_ptr];
    assign push    = cmd_valid && cmd_ready;
    // Pop only when idle and the response slot is free: one op outstanding.
    assign pop     = (state == IDLE) && (count != '0) && !rsp_valid;
    assign tmo_hit = (state == ISSUE) && !alu_valid_out &&
                     (tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{cmd_op_a, cmd_op_b, cmd_op_code, cmd_mode_fp,
                                   cmd_round_mode, cmd_tag};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count     <= count_nxt;
            cmd_ready <= (count_nxt < CNT_W'(DEPTH));
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop && !head.op_code[2])    state_nxt = ISSUE;
            ISSUE:   if (alu_valid_out || tmo_hit)   state_nxt = RELEASE;
            // Hold until the previous done level drops so it cannot
            // complete the next command.
            RELEASE: if (!alu_valid_out)             state_nxt = IDLE;
            default:                                 state_nxt = IDLE;
        endcase
    end

    // FSM: outputs and response load selection
    always_comb begin
        alu_start = (state == ISSUE);
        rsp_load  = 1'b0;
        ld_result = QNAN;
        ld_flags  = FLG_INVAL;
        ld_tag    = iss.tag;
        if (state == IDLE && pop && head.op_code[2]) begin
            // Illegal opcode answered locally, ALU untouched.
            rsp_load = 1'b1;
            ld_tag   = head.tag;
        end else if (state == ISSUE && alu_valid_out) begin
            rsp_load  = 1'b1;
            ld_result = alu_result;
            ld_flags  = alu_flags;
        end else if (tmo_hit) begin
            rsp_load = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss          <= '0;
            tmo_cnt      <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_flags    <= '0;
            rsp_tag      <= '0;
            sticky_flags <= '0;
            timeout_err  <= 1'b0;
        end else begin
            if (pop && !head.op_code[2]) iss <= head;
            tmo_cnt <= (state == ISSUE) ? tmo_cnt + 1'b1 : '0;
            if (rsp_load) begin
                rsp_valid  <= 1'b1;
                rsp_result <= ld_result;
                rsp_flags  <= ld_flags;
                rsp_tag    <= ld_tag;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            // Clear wins over history, but a same-cycle load still lands.
            sticky_flags <= (sticky_clr ? 5'b0 : sticky_flags) |
                            (rsp_load ? ld_flags : 5'b0);
            if (tmo_hit) timeout_err <= 1'b1;
        end
    end

    assign alu_op_a       = iss.op_a;
    assign alu_op_b       = iss.op_b;
    assign alu_op_code    = iss.op_code;
    assign alu_mode_fp    = iss.mode_fp;
    assign alu_round_mode = iss.round_mode;
    assign busy           = (count != '0) || (state != IDLE) || rsp_valid;
endmodule
